pulpemu_reset_ctrl: RTL and testbench



---
 rtl/pulpemu_reset_ctrl.sv | 160 ++++++++++++++++
 tb/tb_pulpemu_reset_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pulpemu_reset_ctrl.sv
// Reset sequencer for the PULP FPGA emulation top: synchronises board reset sources and
// releases peripherals ahead of the SoC. Define PULPEMU_RST_DEBOUNCE_EN to filter the button.
module pulpemu_reset_ctrl #(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 1000,
   parameter int unsigned HOLD_CYCLES     = 64,
   parameter int unsigned PERIPH_LEAD     = 16
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       pad_reset_i,
   input  logic       pad_jtag_trst_ni,
   input  logic       clk_locked_i,
   output logic       periph_rst_no,
   output logic       soc_rst_no,
   output logic       jtag_trst_no,
   output logic       ready_o,
   output logic [1:0] rst_cause_o
);

   localparam int unsigned CNT_MAX = (HOLD_CYCLES > PERIPH_LEAD) ? HOLD_CYCLES : PERIPH_LEAD;
   localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   typedef enum logic [2:0] {
      S_WAIT_LOCK,
      S_HOLD,
      S_REL_PERIPH,
      S_RUN,
      S_JTAG_RST,
      S_HOLD_J
   } state_e;

   typedef enum logic [1:0] {
      CAUSE_BLOCK  = 2'd0,
      CAUSE_BUTTON = 2'd1,
      CAUSE_JTAG   = 2'd2,
      CAUSE_LOCK   = 2'd3
   } cause_e;

   if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 1 || PERIPH_LEAD < 1) begin : g_bad_params
      $error("pulpemu_reset_ctrl: parameter out of range");
   end

   logic [SYNC_STAGES-1:0] btn_q;
   logic [SYNC_STAGES-1:0] trst_q;
   logic [SYNC_STAGES-1:0] lock_q;
   logic                   btn_s;
   logic                   trst_s;
   logic                   lock_s;
   logic                   btn_f;

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples
   // the pre-edge value of its neighbours and the shift chain does not collapse.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         btn_q  <= '0;
         trst_q <= '0;
         lock_q <= '0;
      end else begin
         btn_q  <= {btn_q[SYNC_STAGES-2:0], pad_reset_i};
         trst_q <= {trst_q[SYNC_STAGES-2:0], pad_jtag_trst_ni};
         lock_q <= {lock_q[SYNC_STAGES-2:0], clk_locked_i};
      end
   end

   assign btn_s  = btn_q[SYNC_STAGES-1];
   assign trst_s = trst_q[SYNC_STAGES-1];
   assign lock_s = lock_q[SYNC_STAGES-1];

`ifdef PULPEMU_RST_DEBOUNCE_EN
   localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   logic [DB_W-1:0] db_cnt;

   // btn_f only follows btn_s after DEBOUNCE_CYCLES consecutive cycles of disagreement
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         db_cnt <= '0;
         btn_f  <= 1'b0;
      end else if (btn_s == btn_f) begin
         db_cnt <= '0;
      end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
         db_cnt <= '0;
         btn_f  <= ~btn_f;
      end else begin
         db_cnt <= db_cnt + DB_W'(1);
      end
   end
`else
   assign btn_f = btn_s;
`endif

   state_e           state;
   logic [CNT_W-1:0] cnt;
   logic             abort;

   assign abort = btn_f || !trst_s || !lock_s;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state         <= S_WAIT_LOCK;
         cnt           <= '0;
         rst_cause_o   <= CAUSE_BLOCK;
         periph_rst_no <= 1'b0;
         soc_rst_no    <= 1'b0;
         jtag_trst_no  <= 1'b0;
         ready_o       <= 1'b0;
      end else begin
         // Outputs decode the current state, so they trail each transition by one cycle.
         periph_rst_no <= (state inside {S_REL_PERIPH, S_RUN, S_JTAG_RST, S_HOLD_J});
         soc_rst_no    <= (state == S_RUN);
         jtag_trst_no  <= (state == S_RUN);
         ready_o       <= (state == S_RUN);

         // NOTE: the counter defaults to zero here; the later increment in a counting
         // state overrides it because the last non-blocking assignment wins.
         cnt <= '0;

         case (state)
            S_WAIT_LOCK: begin
               if (lock_s && !btn_f && trst_s) state <= S_HOLD;
            end
            S_HOLD: begin
               if (abort)                                  state <= S_WAIT_LOCK;
               else if (cnt == CNT_W'(HOLD_CYCLES - 1))    state <= S_REL_PERIPH;
               else                                        cnt   <= cnt + CNT_W'(1);
            end
            S_REL_PERIPH: begin
               if (abort)                                  state <= S_WAIT_LOCK;
               else if (cnt == CNT_W'(PERIPH_LEAD - 1))    state <= S_RUN;
               else                                        cnt   <= cnt + CNT_W'(1);
            end
            S_RUN: begin
               if (!lock_s) begin
                  state       <= S_WAIT_LOCK;
                  rst_cause_o <= CAUSE_LOCK;
               end else if (btn_f) begin
                  state       <= S_WAIT_LOCK;
                  rst_cause_o <= CAUSE_BUTTON;
               end else if (!trst_s) begin
                  state       <= S_JTAG_RST;
                  rst_cause_o <= CAUSE_JTAG;
               end
            end
            S_JTAG_RST: begin
               if (!lock_s || btn_f) state <= S_WAIT_LOCK;
               else if (trst_s)      state <= S_HOLD_J;
            end
            S_HOLD_J: begin
               if (!lock_s || btn_f)                       state <= S_WAIT_LOCK;
               else if (!trst_s)                           state <= S_JTAG_RST;
               else if (cnt == CNT_W'(HOLD_CYCLES - 1))    state <= S_RUN;
               else                                        cnt   <= cnt + CNT_W'(1);
            end
            default: state <= S_WAIT_LOCK;
         endcase
      end
   end

endmodule

// File: tb/tb_pulpemu_reset_ctrl.sv
// Self-checking bench for pulpemu_reset_ctrl: random pulse lengths and delays, expected
// output vectors and their change cycles derived from the documented latencies.
module tb_pulpemu_reset_ctrl;

   localparam int unsigned SYNC = 2;
   localparam int unsigned DEB  = 1000;
   localparam int unsigned HOLD = 64;
   localparam int unsigned LEAD = 16;
`ifdef PULPEMU_RST_DEBOUNCE_EN
   localparam int unsigned DB = DEB;
`else
   localparam int unsigned DB = 0;
`endif

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic       pad_reset_i;
   logic       pad_jtag_trst_ni;
   logic       clk_locked_i;
   logic       periph_rst_no;
   logic       soc_rst_no;
   logic       jtag_trst_no;
   logic       ready_o;
   logic [1:0] rst_cause_o;

   pulpemu_reset_ctrl #(
      .SYNC_STAGES     (SYNC),
      .DEBOUNCE_CYCLES (DEB),
      .HOLD_CYCLES     (HOLD),
      .PERIPH_LEAD     (LEAD)
   ) dut (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .pad_reset_i      (pad_reset_i),
      .pad_jtag_trst_ni (pad_jtag_trst_ni),
      .clk_locked_i     (clk_locked_i),
      .periph_rst_no    (periph_rst_no),
      .soc_rst_no       (soc_rst_no),
      .jtag_trst_no     (jtag_trst_no),
      .ready_o          (ready_o),
      .rst_cause_o      (rst_cause_o)
   );

   always #5 clk_i = ~clk_i;

   // Posedge counter; the bench drives and samples on negedges, where cyc is stable.
   int unsigned cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   logic [5:0]  exp_out;
   logic [1:0]  cause_m;

   function automatic logic [5:0] obs();
      return {periph_rst_no, soc_rst_no, jtag_trst_no, ready_o, rst_cause_o};
   endfunction

   function automatic logic [5:0] outv(input logic p, input logic s, input logic j,
                                       input logic r, input logic [1:0] c);
      return {p, s, j, r, c};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)", tag, got, want, cyc);
      end
   endtask

   // Outputs must keep the current expected vector until cycle 'at', then show 'want'.
   task automatic expect_at(input string tag, input int unsigned at, input logic [5:0] want);
      logic [5:0] seen;
      bit         bad;
      bit         waited;
      seen   = obs();
      bad    = 1'b0;
      waited = 1'b0;
      while (cyc < at) begin
         waited = 1'b1;
         if (!bad) begin
            seen = obs();
            bad  = (seen !== exp_out);
         end
         @(negedge clk_i);
      end
      if (waited) check({tag, "_hold"}, 32'(seen), 32'(exp_out));
      check(tag, 32'(obs()), 32'(want));
      exp_out = want;
   endtask

   // Release sequence after all sources were good from drive cycle 'start'.
   task automatic restart(input string tag, input int unsigned start, input bit abort);
      int unsigned c;
      int unsigned c2;
      expect_at({tag, "_periph"}, start + SYNC + HOLD + 2, outv(1, 0, 0, 0, cause_m));
      if (abort) begin
         c = cyc + $urandom_range(0, LEAD - SYNC - 2);
         expect_at({tag, "_in_rel"}, c, exp_out);
         clk_locked_i = 1'b0;
         expect_at({tag, "_lockloss_cause"}, c + SYNC + 1, exp_out);
         expect_at({tag, "_lockloss"}, c + SYNC + 2, outv(0, 0, 0, 0, cause_m));
         c2 = cyc + $urandom_range(5, 30);
         expect_at({tag, "_unlocked"}, c2, exp_out);
         clk_locked_i = 1'b1;
         start = c2;
         expect_at({tag, "_periph2"}, start + SYNC + HOLD + 2, outv(1, 0, 0, 0, cause_m));
      end
      expect_at({tag, "_run"}, start + SYNC + HOLD + LEAD + 2, outv(1, 1, 1, 1, cause_m));
   endtask

   task automatic power_up();
      rst_i            = 1'b1;
      pad_reset_i      = 1'b0;
      pad_jtag_trst_ni = 1'b1;
      clk_locked_i     = 1'b0;
      @(negedge clk_i);
      cause_m = 2'd0;
      check("reset_state", 32'(obs()), 32'(0));
      exp_out = '0;
      expect_at("rst_held", 5, '0);
      rst_i = 1'b0;
      expect_at("wait_lock", 20, '0);
      clk_locked_i = 1'b1;
      restart("pwr", 20, 1'b0);
   endtask

   task automatic button_pulse(input int unsigned len, input bit abort);
      int unsigned c;
      int unsigned e1;
      c  = cyc;
      e1 = c + SYNC + DB + 1;
      pad_reset_i = 1'b1;
      if (len < DB) begin
         expect_at("glitch_high", c + len, exp_out);
         pad_reset_i = 1'b0;
         expect_at("glitch_filtered", c + len + SYNC + DB + 4, exp_out);
      end else begin
         if (c + len < e1) begin
            expect_at("btn_high", c + len, exp_out);
            pad_reset_i = 1'b0;
         end
         cause_m = 2'd1;
         expect_at("btn_cause", e1, {exp_out[5:2], cause_m});
         expect_at("btn_reset", e1 + 1, outv(0, 0, 0, 0, cause_m));
         if (pad_reset_i) begin
            expect_at("btn_held", c + len, exp_out);
            pad_reset_i = 1'b0;
         end
         restart("btn", c + len + DB, abort);
      end
   endtask

   task automatic trst_pulse(input int unsigned len);
      int unsigned c;
      c = cyc;
      pad_jtag_trst_ni = 1'b0;
      cause_m = 2'd2;
      expect_at("trst_cause", c + SYNC + 1, {exp_out[5:2], cause_m});
      expect_at("trst_reset", c + SYNC + 2, outv(1, 0, 0, 0, cause_m));
      expect_at("trst_low", c + len, exp_out);
      pad_jtag_trst_ni = 1'b1;
      expect_at("trst_resume", c + len + SYNC + HOLD + 2, outv(1, 1, 1, 1, cause_m));
   endtask

   task automatic rst_pulse(input bit abort);
      int unsigned c;
      c = cyc;
      rst_i   = 1'b1;
      cause_m = 2'd0;
      expect_at("rst_pulse", c + 1, '0);
      rst_i = 1'b0;
      restart("rst", c + 1, abort);
   endtask

   // Button press timed so its debounced edge reaches the FSM together with lock loss.
   task automatic lock_and_button();
      int unsigned c;
      int unsigned c2;
      pad_reset_i = 1'b1;
      expect_at("lb_press", cyc + DB, exp_out);
      c = cyc;
      clk_locked_i = 1'b0;
      cause_m = 2'd3;
      expect_at("lb_cause", c + SYNC + 1, {exp_out[5:2], cause_m});
      expect_at("lb_reset", c + SYNC + 2, outv(0, 0, 0, 0, cause_m));
      c2 = cyc + $urandom_range(5, 20);
      expect_at("lb_wait", c2, exp_out);
      pad_reset_i  = 1'b0;
      clk_locked_i = 1'b1;
      restart("lb", c2 + DB, 1'b0);
   endtask

   function automatic int unsigned long_len();
      return (DB > 0) ? $urandom_range(DB + SYNC + 2, DB + 600) : $urandom_range(SYNC + 2, 40);
   endfunction

   function automatic int unsigned short_len();
      return (DB > 0) ? $urandom_range(1, DB - 1) : $urandom_range(1, SYNC);
   endfunction

   initial begin
      int unsigned pick;
      power_up();
      button_pulse((DB > 0) ? 500 : 1, 1'b0);
      button_pulse((DB > 0) ? DB - 1 : 2, 1'b0);
      button_pulse((DB > 0) ? 1500 : 10, 1'b0);
      trst_pulse(10);
      rst_pulse(1'b1);
      lock_and_button();
      rst_pulse(1'b0);
      for (int i = 0; i < 8; i++) begin
         pick = $urandom_range(0, 3);
         case (pick)
            0:       button_pulse(long_len(), 1'($urandom_range(0, 1)));
            1:       trst_pulse($urandom_range(SYNC + 2, 20));
            2:       rst_pulse(1'($urandom_range(0, 1)));
            default: button_pulse(short_len(), 1'b0);
         endcase
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded its time budget at cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
